// File: rtl/vend_sequencer.sv
// Credit/vend/change controller: one clocked FSM taking coin and selection pulses,
// dispensing over vend_valid/vend_ready and returning change coin by coin.
// Optional per-slot stock tracking is enabled with the VM_STOCK_TRACK_EN macro.
module vend_sequencer #(
  parameter int SLOTS      = 9,
  parameter int CREDIT_W   = 8,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      coin_valid,
  input  logic [2:0]                coin_type,
  input  logic                      sel_valid,
  input  logic [3:0]                sel_idx,
  input  logic                      cancel,
  input  logic [SLOTS*CREDIT_W-1:0] price_flat,
  output logic                      vend_valid,
  output logic [3:0]                vend_idx,
  input  logic                      vend_ready,
  output logic                      coin_out_valid,
  output logic [2:0]                coin_out_type,
  input  logic                      coin_out_ready,
  output logic [CREDIT_W-1:0]       credit,
  output logic [SLOTS-1:0]          can_afford,
  output logic [SLOTS-1:0]          oos,
  output logic                      price_show,
  output logic [CREDIT_W-1:0]       price_disp,
  output logic                      coin_reject,
  output logic                      sel_deny,
  output logic                      busy,
  output logic [1:0]                state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, VEND = 2'd1, CHANGE = 2'd2} state_t;

  state_t state;

  // Handshakes: a request (vend_valid or coin_out_valid) is raised with its payload
  // and both are held unchanged until the edge that samples ready high with valid.

  function automatic logic [CREDIT_W-1:0] coin_value(input logic [2:0] t);
    case (t)
      3'd0:    coin_value = CREDIT_W'(1);
      3'd1:    coin_value = CREDIT_W'(2);
      3'd2:    coin_value = CREDIT_W'(5);
      3'd3:    coin_value = CREDIT_W'(10);
      3'd4:    coin_value = CREDIT_W'(20);
      3'd5:    coin_value = CREDIT_W'(100);
      default: coin_value = '0;
    endcase
  endfunction

  function automatic logic [2:0] greedy_type(input logic [CREDIT_W-1:0] c);
    if (c >= CREDIT_W'(100))     greedy_type = 3'd5;
    else if (c >= CREDIT_W'(20)) greedy_type = 3'd4;
    else if (c >= CREDIT_W'(10)) greedy_type = 3'd3;
    else if (c >= CREDIT_W'(5))  greedy_type = 3'd2;
    else if (c >= CREDIT_W'(2))  greedy_type = 3'd1;
    else                         greedy_type = 3'd0;
  endfunction

  logic [CREDIT_W-1:0] prices [SLOTS];
  logic [CREDIT_W-1:0] sel_price;
  logic                sel_oos;
  logic                sel_in_range;
  logic [CREDIT_W-1:0] coin_val;
  logic                coin_ok;
  logic                sel_ok;
  logic [CREDIT_W-1:0] idle_credit_nxt;
  logic [CREDIT_W-1:0] change_credit_nxt;

`ifdef VM_STOCK_TRACK_EN
  logic [STOCK_W-1:0] stock [SLOTS];

  always_comb begin
    for (int i = 0; i < SLOTS; i++) oos[i] = (stock[i] == '0);
  end
`else
  logic [STOCK_W-1:0] unused_stock_cfg;
  assign unused_stock_cfg = STOCK_W'(INIT_STOCK);
  assign oos = '0;
`endif

  always_comb begin
    sel_price    = '0;
    sel_oos      = 1'b0;
    sel_in_range = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      prices[i]     = price_flat[i*CREDIT_W +: CREDIT_W];
      can_afford[i] = (credit != '0) && (credit >= prices[i]) && !oos[i];
      if (int'(sel_idx) == i) begin
        sel_in_range = 1'b1;
        sel_price    = prices[i];
        sel_oos      = oos[i];
      end
    end
  end

  // Overflow is judged against the registered credit at one extra bit of width.
  assign coin_val = coin_value(coin_type);
  assign coin_ok  = coin_valid && (coin_type <= 3'd5) &&
                    (({1'b0, credit} + {1'b0, coin_val}) <= {1'b0, {CREDIT_W{1'b1}}});
  assign sel_ok   = sel_valid && !cancel && sel_in_range && (credit != '0) &&
                    (credit >= sel_price) && !sel_oos;
  assign idle_credit_nxt   = (sel_ok ? credit - sel_price : credit) + (coin_ok ? coin_val : '0);
  assign change_credit_nxt = credit - coin_value(coin_out_type);

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      credit         <= '0;
      vend_valid     <= 1'b0;
      vend_idx       <= '0;
      coin_out_valid <= 1'b0;
      coin_out_type  <= '0;
      price_show     <= 1'b0;
      price_disp     <= '0;
      coin_reject    <= 1'b0;
      sel_deny       <= 1'b0;
`ifdef VM_STOCK_TRACK_EN
      for (int i = 0; i < SLOTS; i++) stock[i] <= STOCK_W'(INIT_STOCK);
`endif
    end else begin
      coin_reject <= 1'b0;
      sel_deny    <= 1'b0;
      if (coin_valid || sel_valid || cancel) price_show <= 1'b0;
      case (state)
        IDLE: begin
          credit <= idle_credit_nxt;
          if (coin_valid && !coin_ok) coin_reject <= 1'b1;
          if (cancel) begin
            if (credit != '0) begin
              state          <= CHANGE;
              coin_out_valid <= 1'b1;
              coin_out_type  <= greedy_type(idle_credit_nxt);
            end
          end else if (sel_valid && sel_in_range) begin
            if (credit == '0) begin
              price_disp <= sel_price;
              price_show <= 1'b1;
            end else if (sel_ok) begin
              state      <= VEND;
              vend_valid <= 1'b1;
              vend_idx   <= sel_idx;
`ifdef VM_STOCK_TRACK_EN
              for (int i = 0; i < SLOTS; i++)
                if (int'(sel_idx) == i) stock[i] <= stock[i] - 1'b1;
`endif
            end else begin
              sel_deny <= 1'b1;
            end
          end
        end
        VEND: begin
          if (coin_valid) coin_reject <= 1'b1;
          if (vend_ready) begin
            vend_valid <= 1'b0;
            if (credit != '0) begin
              state          <= CHANGE;
              coin_out_valid <= 1'b1;
              coin_out_type  <= greedy_type(credit);
            end else begin
              state <= IDLE;
            end
          end
        end
        CHANGE: begin
          if (coin_valid) coin_reject <= 1'b1;
          if (coin_out_ready) begin
            credit <= change_credit_nxt;
            if (change_credit_nxt == '0) begin
              state          <= IDLE;
              coin_out_valid <= 1'b0;
              coin_out_type  <= '0;
            end else begin
              coin_out_type <= greedy_type(change_credit_nxt);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
